// File: rtl/booth_seq_ctrl.sv
// Sequencing controller for an iterative radix-2 Booth multiplier (signed WIDTH x WIDTH).
// Latency: WIDTH cycles in RUN after the accepting edge, then the product is held in DONE.
// Backpressure: start is taken only while ready; DONE holds the product until ack (ena gates all).
//
// Ports:
//   clk, rst_n (synchronous, active-low), ena (clock enable for all state)
//   start/a_in/b_in/ready : operand handshake; a_in, b_in sampled on the accepting edge
//   busy                  : high while iterating
//   valid/product/ack     : result handshake; product = {A[WIDTH-1:0], Q}
//
// Optional build macro BOOTH_ZERO_SKIP_EN: a zero operand jumps straight from IDLE to
// DONE with product 0, skipping the iterative run.
module booth_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic                 ready,
    output logic                 busy,
    output logic                 valid,
    input  logic                 ack,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    // A and M carry one guard bit so that M = -2^(WIDTH-1) negates without overflow.
    logic [WIDTH:0]   a_reg;
    logic [WIDTH:0]   m_reg;
    logic [WIDTH-1:0] q_reg;
    logic             q_1;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   a_sum;
    logic [WIDTH:0]   a_sh;
    logic [WIDTH-1:0] q_sh;
    logic             q1_sh;
    logic             zero_op;
    logic             last_iter;

`ifdef BOOTH_ZERO_SKIP_EN
    assign zero_op = (a_in == '0) || (b_in == '0);
`else
    assign zero_op = 1'b0;
`endif

    assign last_iter = (count == CW'(1));

    // One Booth step: recode on {Q[0], Q_1}, then arithmetic right shift of {A, Q, Q_1}.
    always_comb begin
        a_sum = a_reg;
        case ({q_reg[0], q_1})
            2'b01:   a_sum = a_reg + m_reg;
            2'b10:   a_sum = a_reg - m_reg;
            default: a_sum = a_reg;
        endcase
        a_sh  = {a_sum[WIDTH], a_sum[WIDTH:1]};
        q_sh  = {a_sum[0], q_reg[WIDTH-1:1]};
        q1_sh = q_reg[0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (ena) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = zero_op ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // ack wins; start is not sampled here since ready is low.
                if (ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ready = (state == IDLE);
    assign busy  = (state == RUN);
    assign valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg   <= '0;
            m_reg   <= '0;
            q_reg   <= '0;
            q_1     <= 1'b0;
            count   <= '0;
            product <= '0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= '0;
                        m_reg <= {a_in[WIDTH-1], a_in};
                        q_reg <= b_in;
                        q_1   <= 1'b0;
                        count <= CW'(WIDTH);
                        if (zero_op) begin
                            product <= '0;
                        end
                    end
                end
                RUN: begin
                    a_reg <= a_sh;
                    q_reg <= q_sh;
                    q_1   <= q1_sh;
                    count <= count - CW'(1);
                    // Capture the result on the final iteration so it is stable throughout DONE.
                    if (last_iter) begin
                        product <= {a_sh[WIDTH-1:0], q_sh};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
module tb_booth_seq_ctrl;

    localparam int W = 8;
`ifdef BOOTH_ZERO_SKIP_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           ena = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   a_in = '0;
    logic [W-1:0]   b_in = '0;
    logic           ready;
    logic           busy;
    logic           valid;
    logic           ack = 1'b0;
    logic [2*W-1:0] product;

    int checks = 0;
    int failures = 0;

    booth_seq_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .ready   (ready),
        .busy    (busy),
        .valid   (valid),
        .ack     (ack),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed multiplication truncated to 2*W bits.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        int pa;
        int pb;
        pa = int'($signed(a));
        pb = int'($signed(b));
        return (2*W)'(pa * pb);
    endfunction

    function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b);
        if (ZS && (a == '0 || b == '0)) return 0;
        return W;
    endfunction

    // Issue one operand pair, count busy cycles, check result, then ack.
    task automatic do_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int ack_delay);
        int n;
        n = 0;
        while (!ready && n < 50) begin
            step();
            n++;
        end
        chk({tag, "_ready"}, ready, 1);
        a_in = a;
        b_in = b;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        chk({tag, "_lat"}, n, ref_lat(a, b));
        chk({tag, "_valid"}, valid, 1);
        chk({tag, "_prod"}, product, ref_mul(a, b));
        for (int i = 0; i < ack_delay; i++) step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk({tag, "_back_idle"}, {ready, busy, valid}, 3'b100);
    endtask

    initial begin
        int n;
        bit saw_valid;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        // Reset state
        step();
        step();
        chk("rst_outs", {ready, busy, valid}, 3'b100);
        chk("rst_prod", product, 0);
        rst_n = 1'b1;
        step();

        // Test 1: ack tied high, 3*5
        ack = 1'b1;
        a_in = 8'd3;
        b_in = 8'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        chk("t1_lat", n, W);
        chk("t1_valid", valid, 1);
        chk("t1_prod", product, 16'h000F);
        step();
        chk("t1_ready", {ready, busy, valid}, 3'b100);
        ack = 1'b0;

        // Test 2: signed cases and the most-negative corner
        do_mul("t2a", 8'hF9, 8'd6, 0);
        chk("t2a_exact", product, 16'hFFD6);
        do_mul("t2b", 8'h80, 8'h80, 0);
        chk("t2b_exact", product, 16'h4000);

        // Test 3: start during RUN ignored; ack held off in DONE
        a_in = 8'd9;
        b_in = 8'd9;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            if (n == 3) begin
                start = 1'b1;
                a_in = 8'd1;
                b_in = 8'd1;
            end else begin
                start = 1'b0;
            end
            step();
            n++;
        end
        start = 1'b0;
        chk("t3_lat", n, W);
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", valid, 1);
            chk("t3_hold_prod", product, 16'h0051);
            step();
        end
        // start and ack together in DONE: only ack acts
        start = 1'b1;
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("t3_ack_start", {ready, busy, valid}, 3'b100);
        step();
        start = 1'b0;
        chk("t3_next_start", busy, ZS && (a_in == 0) ? 0 : 1);
        n = 0;
        while (!valid && n < 50) begin
            step();
            n++;
        end
        chk("t3_follow_prod", product, ref_mul(a_in, b_in));
        ack = 1'b1;
        step();
        ack = 1'b0;

        // Test 4: reset mid-RUN discards the multiply
        a_in = 8'd10;
        b_in = 8'd10;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t4_rst_outs", {ready, busy, valid}, 3'b100);
        chk("t4_rst_prod", product, 0);
        saw_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (valid) saw_valid = 1'b1;
            step();
        end
        chk("t4_no_valid", saw_valid, 0);
        do_mul("t4b", 8'd2, 8'hFD, 1);
        chk("t4b_exact", product, 16'hFFFA);

        // Test 5: ena low for 3 cycles mid-RUN stretches busy to 11
        a_in = 8'd12;
        b_in = 8'd11;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            if (n == 2) ena = 1'b0;
            if (n == 5) ena = 1'b1;
            step();
            n++;
        end
        chk("t5_lat", n, W + 3);
        chk("t5_prod", product, 16'h0084);
        ena = 1'b0;
        ack = 1'b1;
        step();
        chk("t5_ack_gated", valid, 1);
        ena = 1'b1;
        step();
        ack = 1'b0;
        chk("t5_ack", ready, 1);

        // Test 6: zero operand
        do_mul("t6", 8'd0, 8'h55, 0);

        // Randomized pairs against the arithmetic model
        for (int k = 0; k < 24; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (k == 5) ra = '0;
            if (k == 9) rb = '0;
            if (k == 13) ra = 8'h80;
            do_mul("rnd", ra, rb, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
